// File: rtl/joypad_pkg.sv
// joypad_pkg: shared pad layout, SOCD modes and axis helper for joypad_mp
package joypad_pkg;
  localparam int PAD_W = 32;
  typedef enum logic [3:0] {
    BTN_UP = 4'd0, BTN_DOWN = 4'd1, BTN_LEFT = 4'd2, BTN_RIGHT = 4'd3,
    BTN_A = 4'd4, BTN_B = 4'd5, BTN_X = 4'd6, BTN_Y = 4'd7,
    BTN_L1 = 4'd8, BTN_R1 = 4'd9, BTN_L2 = 4'd10, BTN_R2 = 4'd11,
    BTN_L3 = 4'd12, BTN_R3 = 4'd13, BTN_SELECT = 4'd14, BTN_START = 4'd15
  } btn_e;
  typedef enum logic [1:0] {SOCD_PASS = 2'd0, SOCD_NEUTRAL = 2'd1, SOCD_LAST = 2'd2} socd_mode_e;
  typedef enum logic [3:0] {
    PT_NONE = 4'h0, PT_POCKET = 4'h1, PT_GAMEPAD = 4'h2, PT_KEYBOARD = 4'h3, PT_MOUSE = 4'h4
  } pad_type_e;
  function automatic logic [8:0] axis_mag(input logic [7:0] a);
    return (a >= 8'h80) ? {1'b0, a} - 9'h080 : 9'h080 - {1'b0, a};
  endfunction
endpackage

// File: rtl/analog2dpad_hyst.sv
// analog2dpad_hyst: one analog axis to a {positive,negative} direction pair with deadzone and hysteresis
module analog2dpad_hyst import joypad_pkg::*; #(
  parameter logic [7:0] DEADZONE = 8'h10,
  parameter logic [7:0] HYST     = 8'h04
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] i_axis,
  output logic [1:0] o_next,
  output logic [1:0] o_dir
);
  localparam logic [8:0] ON  = {1'b0, DEADZONE};
  localparam logic [8:0] OFF = {1'b0, DEADZONE - HYST};
  logic [8:0] w_d;
  logic [1:0] r_dir;
  assign w_d = axis_mag(i_axis);
  assign o_next[0] = (i_axis < 8'h80) & (r_dir[0] ? w_d >= OFF : w_d > ON);
  assign o_next[1] = (i_axis > 8'h80) & (r_dir[1] ? w_d >= OFF : w_d > ON);
  assign o_dir = r_dir;
  // direction state; a sign flip clears the old side because its side test fails
  always_ff @(posedge clk_sys)
    if (reset) r_dir <= 2'b00;
    else r_dir <= o_next;
endmodule

// File: rtl/joypad_mp.sv
// joypad_mp: multi-pad sync, analog-to-dpad, SOCD resolution, turbo and change strobes
module joypad_mp import joypad_pkg::*; #(
  parameter int          NUM_PADS    = 4,
  parameter int          SYNC_STAGES = 3,
  parameter logic [7:0]  DEADZONE    = 8'h10,
  parameter logic [7:0]  HYST        = 8'h04,
  parameter int          SOCD_MODE   = 0,
  parameter logic [23:0] TURBO_DIV   = 24'd400000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [NUM_PADS*PAD_W-1:0] cont_key,
  input  logic [NUM_PADS*PAD_W-1:0] cont_joy,
  input  logic [NUM_PADS-1:0]       analog_en,
  input  logic [15:0]               turbo_mask,
  output logic [NUM_PADS*16-1:0]    joystick,
  output logic [NUM_PADS*4-1:0]     pad_type,
  output logic [NUM_PADS*PAD_W-1:0] joy_analog,
  output logic [NUM_PADS*4-1:0]     joy_dpad,
  output logic [NUM_PADS-1:0]       key_changed
);
  localparam socd_mode_e MODE = socd_mode_e'(SOCD_MODE);
  logic [SYNC_STAGES-1:0][NUM_PADS*PAD_W-1:0] r_key_s, r_joy_s;
  logic [NUM_PADS*PAD_W-1:0] w_key, w_joy;
  logic [NUM_PADS*12-1:0] w_unused_mid;
  // synchronise raw pad words into clk_sys
  always_ff @(posedge clk_sys)
    if (reset) begin
      r_key_s <= '0;
      r_joy_s <= '0;
    end else begin
      r_key_s <= {r_key_s[SYNC_STAGES-2:0], cont_key};
      r_joy_s <= {r_joy_s[SYNC_STAGES-2:0], cont_joy};
    end
  assign w_key = r_key_s[SYNC_STAGES-1];
  assign w_joy = r_joy_s[SYNC_STAGES-1];
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [1:0]  w_lx_n, w_ly_n, w_lx_r, w_ly_r;
    logic [15:0] w_btn, w_pre, w_held, w_out;
    logic [3:0]  w_dn, w_merged, w_socd, w_hist_n;
    logic [3:0]  r_prev, r_hist;
    logic [15:0] r_prev_held, r_out;
    logic [23:0] r_cnt, w_cnt_n;
    logic        r_phase, r_chg, w_rise, w_any, w_wrap, w_phase_n;
    analog2dpad_hyst #(.DEADZONE(DEADZONE), .HYST(HYST)) u_lx (
      .clk_sys(clk_sys), .reset(reset), .i_axis(w_joy[p*PAD_W +: 8]),
      .o_next(w_lx_n), .o_dir(w_lx_r));
    analog2dpad_hyst #(.DEADZONE(DEADZONE), .HYST(HYST)) u_ly (
      .clk_sys(clk_sys), .reset(reset), .i_axis(w_joy[p*PAD_W+8 +: 8]),
      .o_next(w_ly_n), .o_dir(w_ly_r));
    assign w_dn = {w_lx_n[1], w_lx_n[0], w_ly_n[1], w_ly_n[0]};
    assign w_btn = w_key[p*PAD_W +: 16];
    assign w_merged = w_btn[3:0] | (analog_en[p] ? w_dn : 4'h0);
    for (genvar k = 0; k < 2; k++) begin : g_pair
      logic [1:0] w_m, w_r;
      assign w_m = w_merged[2*k +: 2];
      assign w_r = w_m & ~r_prev[2*k +: 2];
      assign w_socd[2*k +: 2] = (w_m != 2'b11) ? w_m :
                                (MODE == SOCD_NEUTRAL) ? 2'b00 :
                                (MODE == SOCD_LAST) ? ((w_r == 2'b11) ? 2'b00 : (w_r != 2'b00) ? w_r : r_hist[2*k +: 2]) :
                                2'b11;
      assign w_hist_n[2*k +: 2] = (w_m == 2'b00) ? 2'b00 :
                                  (w_r == 2'b01 || w_r == 2'b10) ? w_r : r_hist[2*k +: 2];
    end
    assign w_pre = {w_btn[15:4], w_socd};
    assign w_held = w_pre & turbo_mask;
    assign w_rise = |(w_held & ~r_prev_held);
    assign w_any = |w_held;
    assign w_wrap = r_cnt == TURBO_DIV - 24'd1;
    assign w_cnt_n = (w_rise || !w_any || w_wrap) ? 24'd0 : r_cnt + 24'd1;
    assign w_phase_n = (w_rise || !w_any) ? 1'b1 : w_wrap ? ~r_phase : r_phase;
    assign w_out = (w_pre & ~turbo_mask) | (w_held & {16{w_phase_n}});
    // processing stage: SOCD history, turbo timing and registered pad outputs
    always_ff @(posedge clk_sys)
      if (reset) begin
        r_prev      <= '0;
        r_hist      <= '0;
        r_prev_held <= '0;
        r_cnt       <= '0;
        r_phase     <= 1'b1;
        r_out       <= '0;
        r_chg       <= 1'b0;
      end else begin
        r_prev      <= w_merged;
        r_hist      <= w_hist_n;
        r_prev_held <= w_held;
        r_cnt       <= w_cnt_n;
        r_phase     <= w_phase_n;
        r_out       <= w_out;
        r_chg       <= w_out != r_out;
      end
    assign joystick[p*16 +: 16] = r_out;
    assign key_changed[p] = r_chg;
    assign joy_dpad[p*4 +: 4] = {w_lx_r[1], w_lx_r[0], w_ly_r[1], w_ly_r[0]};
    assign pad_type[p*4 +: 4] = w_key[p*PAD_W+28 +: 4];
    assign joy_analog[p*PAD_W +: PAD_W] = w_joy[p*PAD_W +: PAD_W];
    assign w_unused_mid[p*12 +: 12] = w_key[p*PAD_W+16 +: 12];
  end
endmodule

// File: tb/tb_joypad_mp.sv
// tb_joypad_mp: table, directed and randomized checks of joypad_mp in all three SOCD modes
module tb_joypad_mp;
  localparam int NP = 4;
  localparam int SS = 3;
  localparam int DIV = 4;
  localparam logic [7:0] DZ = 8'h10;
  localparam logic [7:0] HY = 8'h04;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic [127:0] cont_key = '0;
  logic [127:0] cont_joy = '0;
  logic [3:0] analog_en = '0;
  logic [15:0] turbo_mask = '0;
  logic [63:0] joystick [3];
  logic [15:0] pad_type [3];
  logic [15:0] joy_dpad [3];
  logic [127:0] joy_analog [3];
  logic [3:0] key_changed [3];
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  always #5 clk_sys = ~clk_sys;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    joypad_mp #(.NUM_PADS(NP), .SYNC_STAGES(SS), .DEADZONE(DZ), .HYST(HY),
                .SOCD_MODE(m), .TURBO_DIV(24'(DIV))) u_dut (
      .clk_sys(clk_sys), .reset(reset), .cont_key(cont_key), .cont_joy(cont_joy),
      .analog_en(analog_en), .turbo_mask(turbo_mask), .joystick(joystick[m]),
      .pad_type(pad_type[m]), .joy_analog(joy_analog[m]), .joy_dpad(joy_dpad[m]),
      .key_changed(key_changed[m]));
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // reference model: inputs delayed through a queue, each rule evaluated from its definition
  logic [255:0] q[$];
  logic [3:0] ed [NP];
  logic [15:0] ej [3][NP];
  logic ec [3][NP];
  logic [3:0] pm [3][NP];
  int ts [3][NP][4];
  int age [3][NP];
  logic [15:0] pmh [3][NP];
  int cyc = 0;

  function automatic logic [1:0] hyst(input logic [7:0] ax, input logic [1:0] cur);
    int d;
    logic [1:0] r;
    d = int'(ax) - 128;
    r[0] = (d < 0) && (cur[0] ? (-d >= int'(DZ) - int'(HY)) : (-d > int'(DZ)));
    r[1] = (d > 0) && (cur[1] ? (d >= int'(DZ) - int'(HY)) : (d > int'(DZ)));
    return r;
  endfunction

  always @(posedge clk_sys) begin
    logic [255:0] v;
    logic [1:0] x, y;
    logic [3:0] mg, s;
    logic [15:0] w, mh, o;
    if (reset) begin
      q.delete();
      for (int i = 0; i < SS; i++) q.push_back('0);
      for (int p = 0; p < NP; p++) begin
        ed[p] = '0;
        for (int m = 0; m < 3; m++) begin
          ej[m][p] = '0; ec[m][p] = 1'b0; pm[m][p] = '0; age[m][p] = 0; pmh[m][p] = '0;
          for (int b = 0; b < 4; b++) ts[m][p][b] = 0;
        end
      end
    end else begin
      v = q.pop_front();
      q.push_back({cont_key, cont_joy});
      for (int p = 0; p < NP; p++) begin
        x = hyst(v[p*32 +: 8], ed[p][3:2]);
        y = hyst(v[p*32+8 +: 8], ed[p][1:0]);
        ed[p] = {x, y};
        for (int m = 0; m < 3; m++) begin
          mg = v[128+p*32 +: 4] | (analog_en[p] ? ed[p] : 4'h0);
          for (int b = 0; b < 4; b++) if (mg[b] && !pm[m][p][b]) ts[m][p][b] = cyc;
          s = mg;
          for (int k = 0; k < 2; k++)
            if (mg[2*k] && mg[2*k+1]) begin
              if (m == 1) s[2*k +: 2] = 2'b00;
              else if (m == 2)
                s[2*k +: 2] = (ts[m][p][2*k] > ts[m][p][2*k+1]) ? 2'b01 :
                              (ts[m][p][2*k] < ts[m][p][2*k+1]) ? 2'b10 : 2'b00;
            end
          pm[m][p] = mg;
          w = {v[128+p*32+4 +: 12], s};
          mh = w & turbo_mask;
          if ((mh & ~pmh[m][p]) != 0 || mh == 0) age[m][p] = 0;
          else age[m][p]++;
          o = (w & ~turbo_mask) | ((((age[m][p] / DIV) % 2) == 0) ? mh : 16'h0);
          pmh[m][p] = mh;
          ec[m][p] = o != ej[m][p];
          ej[m][p] = o;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk_sys)
    if (chk_on)
      for (int m = 0; m < 3; m++)
        for (int p = 0; p < NP; p++) begin
          chk($sformatf("model m%0d p%0d joystick", m, p), 128'(joystick[m][p*16 +: 16]), 128'(ej[m][p]));
          chk($sformatf("model m%0d p%0d key_changed", m, p), 128'(key_changed[m][p]), 128'(ec[m][p]));
          chk($sformatf("model m%0d p%0d joy_dpad", m, p), 128'(joy_dpad[m][p*4 +: 4]), 128'(ed[p]));
          chk($sformatf("model m%0d p%0d pad_type", m, p), 128'(pad_type[m][p*4 +: 4]), 128'(q[0][128+p*32+28 +: 4]));
          chk($sformatf("model m%0d p%0d joy_analog", m, p), 128'(joy_analog[m][p*32 +: 32]), 128'(q[0][p*32 +: 32]));
        end

  typedef struct {logic [7:0] lx; logic [7:0] ly; logic [3:0] dpad;} hv_t;
  hv_t hv [12];

  initial begin
    hv[0]  = '{8'h80, 8'h80, 4'b0000};
    hv[1]  = '{8'h91, 8'h80, 4'b1000};
    hv[2]  = '{8'h8D, 8'h80, 4'b1000};
    hv[3]  = '{8'h8C, 8'h80, 4'b1000};
    hv[4]  = '{8'h8B, 8'h80, 4'b0000};
    hv[5]  = '{8'h90, 8'h80, 4'b0000};
    hv[6]  = '{8'h6F, 8'h80, 4'b0100};
    hv[7]  = '{8'h91, 8'h80, 4'b1000};
    hv[8]  = '{8'h80, 8'h80, 4'b0000};
    hv[9]  = '{8'h80, 8'h00, 4'b0001};
    hv[10] = '{8'h80, 8'hFF, 4'b0010};
    hv[11] = '{8'h80, 8'h74, 4'b0000};
    cont_key = '1;
    step(1);
    chk_on = 1;
    step(2);
    chk("rst joystick", 128'(joystick[0]), 128'h0);
    chk("rst pad_type", 128'(pad_type[0]), 128'h0);
    chk("rst key_changed", 128'(key_changed[0]), 128'h0);
    reset = 1'b0;
    step(2);
    chk("sync lat pad_type early", 128'(pad_type[0]), 128'h0);
    step(1);
    chk("sync lat pad_type", 128'(pad_type[0]), 128'hFFFF);
    chk("rst release joystick early", 128'(joystick[0]), 128'h0);
    step(1);
    chk("rst release joystick", 128'(joystick[0]), 128'hFFFF_FFFF_FFFF_FFFF);
    chk("rst release key_changed", 128'(key_changed[0]), 128'hF);
    cont_key = '0;
    cont_joy = {16{8'h80}};
    step(6);
    cont_key[36] = 1'b1;
    step(3);
    chk("latency early", 128'(joystick[0][20]), 128'h0);
    step(1);
    chk("latency joystick", 128'(joystick[0]), 128'h10_0000);
    chk("latency key_changed", 128'(key_changed[0]), 128'b0010);
    step(1);
    chk("latency strobe width", 128'(key_changed[0]), 128'h0);
    cont_key = '0;
    analog_en = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      cont_joy[7:0] = hv[i].lx;
      cont_joy[15:8] = hv[i].ly;
      step(SS + 1);
      chk($sformatf("hyst[%0d] joy_dpad", i), 128'(joy_dpad[0][3:0]), 128'(hv[i].dpad));
      chk($sformatf("hyst[%0d] joystick", i), 128'(joystick[0][3:0]), 128'(hv[i].dpad));
    end
    cont_joy = {16{8'h80}};
    analog_en = '0;
    step(5);
    cont_key[2] = 1'b1;
    step(5);
    cont_key[3] = 1'b1;
    step(SS + 2);
    chk("socd2 later wins", 128'(joystick[2][3:0]), 128'b1000);
    chk("socd1 neutral", 128'(joystick[1][3:0]), 128'b0000);
    chk("socd0 pass", 128'(joystick[0][3:0]), 128'b1100);
    cont_key[3] = 1'b0;
    step(SS + 2);
    chk("socd2 left returns", 128'(joystick[2][3:0]), 128'b0100);
    cont_key[2] = 1'b0;
    step(3);
    cont_key[3:2] = 2'b11;
    step(SS + 1);
    chk("socd2 simultaneous", 128'(joystick[2][3:0]), 128'b0000);
    step(3);
    chk("socd2 simultaneous held", 128'(joystick[2][3:0]), 128'b0000);
    cont_key = '0;
    turbo_mask = 16'h0020;
    step(5);
    cont_key[5] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step(1);
      if (k >= 3 && k < 23)
        chk($sformatf("turbo k%0d", k), 128'(joystick[0][5]), 128'((((k - 3) / DIV) % 2) == 0));
      if (k == 23) chk("turbo release", 128'(joystick[0][5]), 128'h0);
      if (k == 19) cont_key[5] = 1'b0;
    end
    step(2);
    cont_key[5] = 1'b1;
    step(SS + 1);
    chk("turbo repress", 128'(joystick[0][5]), 128'h1);
    cont_key[2] = 1'b1;
    step(2);
    cont_key[3] = 1'b1;
    for (int i = 0; i < 20 && joystick[0][5]; i++) step(1);
    chk("turbo phase0 reached", 128'(joystick[0][5]), 128'h0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(SS + 1);
    chk("turbo after reset", 128'(joystick[0][5]), 128'h1);
    chk("socd2 history after reset", 128'(joystick[2][3:0]), 128'b0000);
    step(3);
    chk("socd2 history empty", 128'(joystick[2][3:0]), 128'b0000);
    for (int c = 0; c < 2000; c++) begin
      int p, v;
      p = $urandom_range(0, NP - 1);
      if ($urandom_range(0, 3) == 0) cont_key[p*32 + $urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) cont_key[p*32+28 +: 4] = 4'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        v = 128 + $urandom_range(0, 60) - 30;
        cont_joy[p*32 + 8*$urandom_range(0, 3) +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(v);
      end
      if ($urandom_range(0, 31) == 0) analog_en = 4'($urandom);
      if ($urandom_range(0, 63) == 0)
        case ($urandom_range(0, 4))
          0: turbo_mask = 16'h0000;
          1: turbo_mask = 16'h0020;
          2: turbo_mask = 16'h00F0;
          3: turbo_mask = 16'h000C;
          default: turbo_mask = 16'($urandom);
        endcase
      reset = ($urandom_range(0, 399) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
